// File: rtl/injection_sched.sv
// injection_sched: frame-boundary scheduler that injects BOE/EOE event
// frames into a serializer stream of idle fill words.
module injection_sched #(
  parameter logic [63:0] FILL_WORD      = 64'hFFFFFF00FFFFFFFF,
  parameter logic [3:0]  HOLDOFF_FRAMES = 4'd0
) (
  input  logic        clk_400p,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sync,
  input  logic [1:0]  req,
  input  logic        clr_ovf,
  output logic [1:0]  grant,
  output logic [63:0] frame_data,
  output logic        frame_load,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] evt_count
);

  typedef enum logic [1:0] {
    IDLE,
    BOE,
    EOE,
    GAP
  } state_t;

  state_t     state;
  logic [1:0] req_q;
  logic [1:0] pending;
  logic [1:0] edge_det;
  logic [1:0] win;
  logic [1:0] gnt;
  logic       start;
  logic       src;
  logic       last;
  logic [6:0] tag;
  logic [3:0] cnt;

  assign edge_det = req & ~req_q;
  assign start    = sync && (state == IDLE) && enable && (|pending);
  assign gnt      = start ? win : 2'b00;
  assign busy     = (state != IDLE) || (|pending);

  // last holds the requester granted most recently; it loses a tie
  always_comb begin
    win = pending;
    if (pending == 2'b11)
      win = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_400p or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      frame_data <= FILL_WORD;
      frame_load <= 1'b0;
      grant      <= 2'b00;
      pending    <= 2'b00;
      req_q      <= 2'b00;
      overflow   <= 1'b0;
      evt_count  <= 16'd0;
      tag        <= 7'd0;
      src        <= 1'b0;
      last       <= 1'b1;
      cnt        <= 4'd0;
    end else begin
      req_q      <= req;
      pending    <= (pending & ~gnt) | edge_det;
      grant      <= gnt;
      frame_load <= sync;
      if (|(edge_det & pending & ~gnt))
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
      if (sync) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              src        <= win[1];
              last       <= win[1];
              frame_data <= {8'hDA, 7'h00, win[1], 16'h0000,
                             16'hABCD, evt_count};
              state      <= BOE;
            end else begin
              frame_data <= FILL_WORD;
            end
          end
          BOE: begin
            frame_data <= {8'hEE, 1'b0, tag, 5'h00, overflow, 10'h000,
                           8'hDA, 7'h00, src, 16'h0000};
            evt_count  <= evt_count + 16'd1;
            tag        <= tag + 7'd1;
            state      <= EOE;
          end
          EOE: begin
            frame_data <= FILL_WORD;
            if (HOLDOFF_FRAMES != 4'd0) begin
              cnt   <= HOLDOFF_FRAMES;
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end
          GAP: begin
            frame_data <= FILL_WORD;
            cnt        <= cnt - 4'd1;
            if (cnt == 4'd1)
              state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
